// File: rtl/acoustivdy_pkg.sv
// acoustivdy_pkg
// Shared definitions for the vdy multiply-accumulate pipeline:
//   - prod_width / acc_width : derive the product (PW) and accumulator (AW) widths
//   - mac_beat_t             : one input beat (valid, accumulate controls, operands)
//   - stage_ok / shift_ok /
//     operands_ok            : parameter legality checks used at elaboration time
// Operands are carried at OP_MAX_W bits in mac_beat_t. The unsigned operand is
// zero-extended into that field and the signed operand is sign-extended.
package acoustivdy_pkg;

  localparam int OP_MAX_W = 32;

  typedef struct packed {
    logic                valid;
    logic                acc_en;
    logic                acc_first;
    logic [OP_MAX_W-1:0] op0;
    logic [OP_MAX_W-1:0] op1;
  } mac_beat_t;

  // The unsigned operand gains one zero bit so a signed multiply can be used.
  function automatic int prod_width(input int d0w, input int d1w);
    return d0w + d1w + 1;
  endfunction

  function automatic int acc_width(input int pw, input int guard);
    return pw + guard;
  endfunction

  function automatic bit stage_ok(input int num_stage);
    return num_stage >= 3;
  endfunction

  function automatic bit shift_ok(input int shift, input int pw);
    return (shift >= 0) && (shift < pw);
  endfunction

  function automatic bit operands_ok(input int d0w, input int d1w);
    return (d0w >= 1) && (d1w >= 2) && (d0w <= OP_MAX_W) && (d1w <= OP_MAX_W);
  endfunction

endpackage

// File: rtl/acoustivdy_round_sat.sv
// acoustivdy_round_sat
// Combinational output conversion for the accumulator value:
// round-to-nearest (half toward +inf), arithmetic right shift, then
// saturation (ACOUSTIVDY_SAT_EN defined) or two's-complement wrap.
// Ports:
//   acc_in : AW-bit signed accumulator value (acc_next)
//   dout   : DW-bit signed result
//   sat    : 1 when the result was clamped (constant 0 without ACOUSTIVDY_SAT_EN)
// Configuration macro: ACOUSTIVDY_SAT_EN
module acoustivdy_round_sat #(
  parameter int AW    = 28,
  parameter int SHIFT = 0,
  parameter int DW    = 15
) (
  input  logic [AW-1:0] acc_in,
  output logic [DW-1:0] dout,
  output logic          sat
);

  // One extra bit so the rounding increment can never overflow.
  localparam int RW = AW + 1;

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;

  assign acc_ext = $signed({acc_in[AW-1], acc_in});

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      assign rounded = acc_ext + $signed(HALF);
    end else begin : g_no_round
      assign rounded = acc_ext;
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;

  generate
    if (DW < RW) begin : g_narrow
`ifdef ACOUSTIVDY_SAT_EN
      // The value fits when every bit from DW-1 upward equals the sign bit.
      logic [RW-DW:0] hi_bits;
      logic           fits;
      assign hi_bits = shifted[RW-1:DW-1];
      assign fits    = (&hi_bits) | ~(|hi_bits);
      always_comb begin
        dout = shifted[DW-1:0];
        sat  = 1'b0;
        if (!fits) begin
          sat  = 1'b1;
          dout = shifted[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
      end
`else
      logic unused_hi;
      assign unused_hi = ^shifted[RW-1:DW];
      assign dout      = shifted[DW-1:0];
      assign sat       = 1'b0;
`endif
    end else begin : g_wide
      // Output is at least as wide as the shifted value: no overflow possible.
      assign dout = DW'(shifted);
      assign sat  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/acoustivdy_mac_pipe.sv
// acoustivdy_mac_pipe
// Pipelined unsigned x signed multiply-accumulate for the vdy datapath.
//   S1: register input beat      S2: PW-bit product, sign-extended to AW
//   S3: accumulate + round/shift + saturate/wrap, registered into dout/sat
//   S4..S_NUM_STAGE: plain delay registers (generate loop)
// Ports:
//   clk, reset (async, active-high), ce (0 freezes every register)
//   in_valid, din0 (unsigned), din1 (signed), acc_en, acc_first : input beat
//   out_valid, dout (signed), sat : result, NUM_STAGE ce=1 edges later
// Configuration macro: ACOUSTIVDY_SAT_EN (saturate instead of wrap).
module acoustivdy_mac_pipe
  import acoustivdy_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 15,
  parameter int SHIFT      = 0,
  parameter int ACC_GUARD  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_first,
  output logic                  out_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int AW = acc_width(PW, ACC_GUARD);
  localparam int ND = NUM_STAGE - 3;  // number of plain delay stages after S3

  localparam int unused_id = ID;  // instance tag only

  generate
    if (!stage_ok(NUM_STAGE)) begin : g_err_stage
      $error("acoustivdy_mac_pipe: NUM_STAGE must be >= 3");
    end
    if (!shift_ok(SHIFT, PW)) begin : g_err_shift
      $error("acoustivdy_mac_pipe: SHIFT must be in 0..PW-1");
    end
    if (!operands_ok(din0_WIDTH, din1_WIDTH)) begin : g_err_ops
      $error("acoustivdy_mac_pipe: operand widths out of range");
    end
  endgenerate

  // ---------------- S1: input beat ----------------
  mac_beat_t s1_d, s1_q;

  always_comb begin
    s1_d           = '0;
    s1_d.valid     = in_valid;
    s1_d.acc_en    = acc_en;
    s1_d.acc_first = acc_first;
    s1_d.op0       = OP_MAX_W'(din0);
    s1_d.op1       = OP_MAX_W'($signed(din1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
    end else if (ce) begin
      s1_q <= s1_d;
    end
  end

  // Bits above the configured operand widths are carried but never used.
  logic unused_op_bits;
  assign unused_op_bits = ^{s1_q.op0, s1_q.op1};

  // ---------------- S2: product ----------------
  logic signed [PW-1:0] a_ext, b_ext, prod_pw;
  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_acc_en_d, s2_acc_en_q;
  logic                 s2_acc_first_d, s2_acc_first_q;
  logic [AW-1:0]        prod_d, prod_q;

  always_comb begin
    a_ext          = PW'(s1_q.op0[din0_WIDTH-1:0]);
    b_ext          = PW'($signed(s1_q.op1[din1_WIDTH-1:0]));
    prod_pw        = a_ext * b_ext;
    prod_d         = AW'(prod_pw);
    s2_valid_d     = s1_q.valid;
    s2_acc_en_d    = s1_q.acc_en;
    s2_acc_first_d = s1_q.acc_first;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q     <= 1'b0;
      s2_acc_en_q    <= 1'b0;
      s2_acc_first_q <= 1'b0;
      prod_q         <= '0;
    end else if (ce) begin
      s2_valid_q     <= s2_valid_d;
      s2_acc_en_q    <= s2_acc_en_d;
      s2_acc_first_q <= s2_acc_first_d;
      prod_q         <= prod_d;
    end
  end

  // ---------------- S3: accumulate and convert ----------------
  // Index 0 of the stage arrays is the S3 result register; index ND is the output.
  logic                  stg_valid_q [0:ND];
  logic [dout_WIDTH-1:0] stg_dout_q  [0:ND];
  logic                  stg_sat_q   [0:ND];

  logic [AW-1:0]         acc_d, acc_q, acc_next;
  logic [dout_WIDTH-1:0] rs_dout;
  logic                  rs_sat;
  logic                  s3_valid_d, s3_sat_d;
  logic [dout_WIDTH-1:0] s3_dout_d;

  always_comb begin
    // Pass-through beats (acc_en=0) and first beats both start from the product.
    acc_next = prod_q;
    if (s2_acc_en_q && !s2_acc_first_q) begin
      acc_next = acc_q + prod_q;
    end
    acc_d = acc_q;
    if (s2_valid_q && s2_acc_en_q) begin
      acc_d = acc_next;
    end
  end

  acoustivdy_round_sat #(
    .AW    (AW),
    .SHIFT (SHIFT),
    .DW    (dout_WIDTH)
  ) u_round_sat (
    .acc_in (acc_next),
    .dout   (rs_dout),
    .sat    (rs_sat)
  );

  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_sat_d   = s2_valid_q & rs_sat;
    s3_dout_d  = s2_valid_q ? rs_dout : stg_dout_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q          <= '0;
      stg_valid_q[0] <= 1'b0;
      stg_dout_q[0]  <= '0;
      stg_sat_q[0]   <= 1'b0;
    end else if (ce) begin
      acc_q          <= acc_d;
      stg_valid_q[0] <= s3_valid_d;
      stg_dout_q[0]  <= s3_dout_d;
      stg_sat_q[0]   <= s3_sat_d;
    end
  end

  // ---------------- S4..S_NUM_STAGE: delay stages ----------------
  // dout is copied unconditionally: stage 0 already holds the last valid result.
  genvar gi;
  generate
    for (gi = 1; gi <= ND; gi++) begin : g_dly
      logic                  valid_d, sat_d;
      logic [dout_WIDTH-1:0] dout_d;

      always_comb begin
        valid_d = stg_valid_q[gi-1];
        sat_d   = stg_sat_q[gi-1];
        dout_d  = stg_dout_q[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stg_valid_q[gi] <= 1'b0;
          stg_dout_q[gi]  <= '0;
          stg_sat_q[gi]   <= 1'b0;
        end else if (ce) begin
          stg_valid_q[gi] <= valid_d;
          stg_dout_q[gi]  <= dout_d;
          stg_sat_q[gi]   <= sat_d;
        end
      end
    end
  endgenerate

  assign out_valid = stg_valid_q[ND];
  assign dout      = stg_dout_q[ND];
  assign sat       = stg_sat_q[ND];

endmodule

// File: tb/tb_acoustivdy_mac_pipe.sv
// Directed bench for acoustivdy_mac_pipe. Four instances share the input
// stimulus: u_a (NUM_STAGE=4, SHIFT=0), u_r1 (SHIFT=1), u_r8 (SHIFT=8),
// all NUM_STAGE=4, and u_d (all defaults, NUM_STAGE=3).
module tb_acoustivdy_mac_pipe;

`ifdef ACOUSTIVDY_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, acc_en, acc_first;
  logic [7:0]  din0;
  logic [14:0] din1;

  logic        ov_a, sat_a, ov_r1, sat_r1, ov_r8, sat_r8, ov_d, sat_d;
  logic [14:0] dout_a, dout_r1, dout_r8, dout_d;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int got_q[$];
  int exp_acc[4] = '{200, 50, 7, 51};
  int exp_ce[5]  = '{-20, -42, -66, -92, -120};

  always #5 clk = ~clk;

  acoustivdy_mac_pipe #(.NUM_STAGE(4), .SHIFT(0)) u_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov_a), .dout(dout_a), .sat(sat_a));

  acoustivdy_mac_pipe #(.NUM_STAGE(4), .SHIFT(1)) u_r1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov_r1), .dout(dout_r1), .sat(sat_r1));

  acoustivdy_mac_pipe #(.NUM_STAGE(4), .SHIFT(8)) u_r8 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov_r8), .dout(dout_r8), .sat(sat_r8));

  acoustivdy_mac_pipe u_d (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov_d), .dout(dout_d), .sat(sat_d));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d0, input int d1, input logic en, input logic first);
    in_valid  = 1'b1;
    din0      = d0[7:0];
    din1      = d1[14:0];
    acc_en    = en;
    acc_first = first;
  endtask

  // One beat, then three idle edges: the beat is at every NUM_STAGE=4 output.
  task automatic send(input int d0, input int d1, input logic en, input logic first);
    drive(d0, d1, en, first);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Records u_a results produced by ce=1 edges only (held outputs are not new).
  initial begin
    logic ce_at;
    forever begin
      @(posedge clk);
      ce_at = ce;
      #1;
      if (ce_at && ov_a) got_q.push_back(int'($signed(dout_a)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_first = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) tick();
    check("rst_out_valid", ov_a, 0);
    check("rst_dout", $signed(dout_a), 0);
    check("rst_sat", sat_a, 0);
    reset = 1'b0;

    // Latency: NUM_STAGE=4 result after edge 4, default instance after edge 3.
    drive(2, 100, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1) in_valid = 1'b0;
      check($sformatf("lat4_valid_edge%0d", e), ov_a, (e == 4) ? 1 : 0);
      check($sformatf("lat3_valid_edge%0d", e), ov_d, (e == 3) ? 1 : 0);
      if (e == 4) check("lat4_dout", $signed(dout_a), 200);
      if (e == 3) check("lat3_dout", $signed(dout_d), 200);
    end
    check("hold_dout", $signed(dout_a), 200);

    // Rounding
    send(3, 1, 1'b0, 1'b0);
    check("round_s1_3x1", $signed(dout_r1), 2);
    send(1, -3, 1'b0, 1'b0);
    check("round_s1_1xm3", $signed(dout_r1), -1);
    send(255, -16384, 1'b0, 1'b0);
    check("round_s8_dout", $signed(dout_r8), -16320);
    check("round_s8_sat", sat_r8, 0);
    check("neg_bound_dout", $signed(dout_a), -16384);
    check("neg_bound_sat", sat_a, SAT_EN ? 1 : 0);

    // Positive overflow
    send(255, 16383, 1'b0, 1'b0);
    check("pos_ovf_dout", $signed(dout_a), SAT_EN ? 16383 : 16129);
    check("pos_ovf_sat", sat_a, SAT_EN ? 1 : 0);
    tick();
    check("sat_clear_idle", sat_a, 0);
    check("valid_clear_idle", ov_a, 0);

    // Back-to-back accumulation
    got_q.delete();
    drive(2, 100, 1'b1, 1'b1);  tick();
    drive(3, -50, 1'b1, 1'b0);  tick();
    drive(1, 7, 1'b0, 1'b0);    tick();
    drive(1, 1, 1'b1, 1'b0);    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("acc_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("acc_beat%0d", i), (i < got_q.size()) ? got_q[i] : -99999, exp_acc[i]);

    // CE stall with a valid result sitting at the output
    got_q.delete();
    for (int k = 0; k < 5; k++) begin
      drive(k + 1, -(20 + k), 1'b0, 1'b0);
      if (k == 4) begin
        ce = 1'b0;
        repeat (3) tick();
        check("stall_valid_held", ov_a, 1);
        check("stall_dout_held", $signed(dout_a), -20);
        ce = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    check("ce_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("ce_beat%0d", i), (i < got_q.size()) ? got_q[i] : -99999, exp_ce[i]);

    // Reset with accumulator=200 and two beats in flight
    drive(2, 100, 1'b1, 1'b1);  tick();
    drive(1, 3, 1'b0, 1'b0);    tick();
    drive(1, 4, 1'b0, 1'b0);    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", ov_a, 1);
    check("pre_rst_dout", $signed(dout_a), 200);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", ov_a, 0);
    check("async_rst_dout", $signed(dout_a), 0);
    check("async_rst_sat", sat_a, 0);
    tick();
    reset = 1'b0;
    got_q.delete();
    repeat (6) tick();
    check("no_stale_beats", got_q.size(), 0);
    send(1, 5, 1'b1, 1'b0);
    check("post_rst_valid", ov_a, 1);
    check("post_rst_acc", $signed(dout_a), 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
